parameters: RTL

Iterative 32-bit integer divide unit for the Nios II core. It is the inverse-operation counterpart to the pipelined multiply cell. It accepts operands from the E stage with a start pulse and computes one quotient bit per cycle (radix-2 restoring). It then returns quotient and remainder to the M stage with a one-cycle done strobe, and the pipeline stalls on busy while the unit works.

---
 rtl/parameters.sv | 119 +++++++++++
 1 files changed

// File: rtl/parameters.sv
// Iterative radix-2 restoring divider for the Nios II pipeline.
// One quotient bit per cycle, fixed 34-cycle latency, kill aborts.
module parameters (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] E_src1,
  input  logic [31:0] E_src2,
  input  logic        E_div_start,
  input  logic        E_div_signed,
  input  logic        M_div_kill,
  output logic        M_div_busy,
  output logic        M_div_done,
  output logic [31:0] M_div_quot,
  output logic [31:0] M_div_rem,
  output logic        M_div_dbz
);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIXUP,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [32:0] prem;
  logic [5:0]  cnt;
  logic        qneg;
  logic        rneg;
  logic        dbz;
  logic [31:0] orig;

  logic        accept;
  logic        sign1;
  logic        sign2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign accept  = E_div_start && !M_div_kill &&
                   (state == IDLE || state == DONE);
  assign sign1   = E_div_signed & E_src1[31];
  assign sign2   = E_div_signed & E_src2[31];
  assign mag1    = sign1 ? (32'd0 - E_src1) : E_src1;
  assign mag2    = sign2 ? (32'd0 - E_src2) : E_src2;
  assign shifted = {prem[31:0], dvd[31]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs};
  assign quot_fix = qneg ? (32'd0 - dvd) : dvd;
  assign rem_fix  = rneg ? (32'd0 - prem[31:0]) : prem[31:0];

  assign M_div_busy = (state == ITER) || (state == FIXUP);
  assign M_div_done = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode; kill overrides everything
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = ITER;
      ITER:  if (cnt == 6'd31) state_nx = FIXUP;
      FIXUP: state_nx = DONE;
      DONE:  state_nx = accept ? ITER : IDLE;
      default: state_nx = IDLE;
    endcase
    if (M_div_kill) state_nx = IDLE;
  end

  // Operand capture, shift-subtract iteration and result registering
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dvd        <= '0;
      dvs        <= '0;
      prem       <= '0;
      cnt        <= '0;
      qneg       <= 1'b0;
      rneg       <= 1'b0;
      dbz        <= 1'b0;
      orig       <= '0;
      M_div_quot <= '0;
      M_div_rem  <= '0;
      M_div_dbz  <= 1'b0;
    end else if (accept) begin
      dvd  <= mag1;
      dvs  <= mag2;
      prem <= '0;
      cnt  <= '0;
      qneg <= sign1 ^ sign2;
      rneg <= sign1;
      dbz  <= (E_src2 == 32'd0);
      orig <= E_src1;
    end else if (state == ITER) begin
      cnt <= cnt + 6'd1;
      if (!diff[33]) begin
        prem <= diff[32:0];
        dvd  <= {dvd[30:0], 1'b1};
      end else begin
        prem <= shifted;
        dvd  <= {dvd[30:0], 1'b0};
      end
    end else if (state == FIXUP && !M_div_kill) begin
      M_div_quot <= dbz ? 32'hFFFF_FFFF : quot_fix;
      M_div_rem  <= dbz ? orig : rem_fix;
      M_div_dbz  <= dbz;
    end
  end

endmodule
